// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave responder: width and idle-byte
// defaults, the frame FSM state type and the fixed SPI mode.
package spi_pkg;

    localparam int unsigned          SPI_DATA_WIDTH = 8;
    localparam logic [7:0]           SPI_IDLE_BYTE  = 8'hFF;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam logic                 SPI_CPOL       = 1'b0;
    localparam logic                 SPI_CPHA       = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_responder_if.sv
// Pin and byte-stream bundle of the SPI slave responder. The slave modport is
// the responder's view; the master modport is the SPI master / host view.
interface spi_slave_responder_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
);

    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  selected;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, selected
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, selected
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a
// previous-value flop; level and single-cycle rise/fall strobes.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchroniser and remember the last level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
            r_prev <= RESET_VALUE;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder: oversampled pins, byte receive with a one-cycle
// valid pulse, one-entry response buffer with IDLE_BYTE substitution.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = DATA_WIDTH'(SPI_IDLE_BYTE)
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_responder_if.slave  bus
);

    localparam int unsigned           CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load;
    logic                  w_tx_step;
    logic                  w_rx_step;
    logic                  w_frame_end;

    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic                  r_rx_valid;
    logic                  r_underrun;
    logic                  r_selected;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] w_rx_byte;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .i_async(bus.spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // cs_n resets to the asserted level: a frame already in progress at reset
    // produces no falling edge until cs_n has been seen high again.
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .i_async(bus.spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .i_async(bus.spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_edges = &{1'b0, w_sclk_level, w_cs_level, w_mosi_rise, w_mosi_fall};
    assign w_rx_byte      = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle datapath strobes; cs edges take priority.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_tx_step    = 1'b0;
        w_rx_step    = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_next_state = ST_SHIFT;
                    w_load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_next_state = ST_IDLE;
                    w_frame_end  = 1'b1;
                end else if (w_sclk_rise) begin
                    w_rx_step = 1'b1;
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == '0) begin
                        w_load = 1'b1;
                    end else begin
                        w_tx_step = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // One-entry response buffer: filled by the host, drained by byte loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end
            if (bus.tx_valid && !r_buf_full) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    // Transmit shifter: load on byte start, shift on non-boundary falling edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_shift <= '1;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                if (r_buf_full) begin
                    r_tx_shift <= r_buf;
                end else begin
                    r_tx_shift <= IDLE_BYTE;
                    r_underrun <= 1'b1;
                end
            end else if (w_tx_step) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Receive shifter, bit counter and completed-byte handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load || w_frame_end) begin
                r_bit_cnt <= '0;
            end else if (w_rx_step) begin
                r_rx_shift <= w_rx_byte;
                if (r_bit_cnt == CNT_LAST) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Selection flag drives miso enable and the selected status output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_selected <= 1'b0;
        end else if (w_load) begin
            r_selected <= 1'b1;
        end else if (w_frame_end) begin
            r_selected <= 1'b0;
        end
    end

    assign bus.spi_miso    = r_selected ? r_tx_shift[DATA_WIDTH-1] : 1'b1;
    assign bus.spi_miso_oe = r_selected;
    assign bus.selected    = r_selected;
    assign bus.tx_ready    = ~r_buf_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_underrun;

endmodule
